// File: rtl/mel_pkg.sv
// Shared definitions for the log-mel window buffer: stream defaults, read FSM states,
// and modulo-DEPTH address arithmetic.
package mel_pkg;
  localparam int MEL_BINS_DEF = 40;
  localparam int OW_DEF       = 16;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} rd_state_e;

  // Operands are always below depth, so a single conditional subtract suffices.
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned depth);
    int unsigned s;
    s = a + b;
    return (s >= depth) ? s - depth : s;
  endfunction
endpackage

// File: rtl/mel_buf_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
module mel_buf_ram
  import mel_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int OW    = OW_DEF,
  parameter int AW    = $clog2(DEPTH)
)(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [OW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [OW-1:0] rdata
);
  logic [OW-1:0] mem_q [DEPTH];
  logic [OW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/mel_window_buffer.sv
// Circular store of NUM_FRAMES+1 log-mel frames; streams the newest NUM_FRAMES frames,
// oldest first, to the CNN over valid/ready.
module mel_window_buffer
  import mel_pkg::*;
#(
  parameter int MEL_BINS   = MEL_BINS_DEF,
  parameter int OW         = OW_DEF,
  parameter int NUM_FRAMES = 32,
  parameter int DEPTH      = (NUM_FRAMES + 1) * MEL_BINS,
  parameter int AW         = $clog2(DEPTH)
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [OW-1:0] mel_in,
  input  logic          mel_valid,
  input  logic          mel_frame_done,
  output logic          win_ready,
  input  logic          win_start,
  output logic [OW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          err_short,
  output logic          err_nodone,
  output logic          overrun
);
  localparam int TOTAL = NUM_FRAMES * MEL_BINS;
  localparam int CW    = $clog2(TOTAL);
  localparam int BW    = (MEL_BINS > 1) ? $clog2(MEL_BINS) : 1;
  localparam int FW    = $clog2(NUM_FRAMES + 1);

  // ---------------- write side ----------------
  logic [BW-1:0] bin_cnt_q, bin_cnt_d;
  logic [AW-1:0] wr_base_q, wr_base_d;
  logic [FW-1:0] frames_q, frames_d;
  logic          err_short_q, err_short_d;
  logic          err_nodone_q, err_nodone_d;
  logic          overrun_q, overrun_d;
  logic          ram_we;
  logic [AW-1:0] wr_addr;
  logic          wr_block;

  // ---------------- read side ----------------
  rd_state_e     state_q, state_d;
  logic [AW-1:0] rd_base_q, rd_base_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic          issue_done_q, issue_done_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          ram_re, ram_vld_q, ram_vld_d;
  logic [OW-1:0] ram_rdata;

  logic [1:0][OW-1:0] fifo_q, fifo_d;
  logic          fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
  logic [1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [1:0]    occ;
  logic          pop;

  // Once the spare slot is committed, the write slot becomes the window's oldest slot.
  assign wr_block = (state_q == STREAM) && (wr_base_q == rd_base_q);
  assign wr_addr  = wr_base_q + AW'(bin_cnt_q);

  always_comb begin
    bin_cnt_d    = bin_cnt_q;
    wr_base_d    = wr_base_q;
    frames_d     = frames_q;
    ram_we       = 1'b0;
    err_short_d  = 1'b0;
    err_nodone_d = 1'b0;
    overrun_d    = 1'b0;
    if (wr_block) begin
      overrun_d = mel_valid;
    end else if (mel_valid && (bin_cnt_q == BW'(MEL_BINS - 1))) begin
      ram_we       = 1'b1;
      bin_cnt_d    = '0;
      wr_base_d    = AW'(wrap_add(32'(wr_base_q), MEL_BINS, DEPTH));
      err_nodone_d = !mel_frame_done;
      if (frames_q != FW'(NUM_FRAMES)) frames_d = frames_q + FW'(1);
    end else if (mel_frame_done) begin
      bin_cnt_d   = '0;
      err_short_d = 1'b1;
    end else if (mel_valid) begin
      ram_we    = 1'b1;
      bin_cnt_d = bin_cnt_q + BW'(1);
    end
  end

  assign win_ready = (state_q == IDLE) && (frames_q == FW'(NUM_FRAMES));
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_data  = out_valid ? fifo_q[fifo_rp_q] : '0;
  assign out_last  = out_valid && (out_cnt_q == CW'(TOTAL - 1));
  assign pop       = out_valid && out_ready;
  // Words in flight plus words held never exceed the two skid entries.
  assign occ       = fifo_cnt_q + {1'b0, ram_vld_q};

  always_comb begin
    state_d      = state_q;
    rd_base_d    = rd_base_q;
    rd_addr_d    = rd_addr_q;
    rd_cnt_d     = rd_cnt_q;
    issue_done_d = issue_done_q;
    out_cnt_d    = out_cnt_q;
    ram_re       = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_start && win_ready) begin
          state_d      = STREAM;
          rd_base_d    = AW'(wrap_add(32'(wr_base_q), MEL_BINS, DEPTH));
          rd_addr_d    = AW'(wrap_add(32'(wr_base_q), MEL_BINS, DEPTH));
          rd_cnt_d     = '0;
          issue_done_d = 1'b0;
          out_cnt_d    = '0;
        end
      end
      STREAM: begin
        if (!issue_done_q && ((occ != 2'd2) || pop)) begin
          ram_re    = 1'b1;
          rd_addr_d = AW'(wrap_add(32'(rd_addr_q), 1, DEPTH));
          rd_cnt_d  = rd_cnt_q + CW'(1);
          if (rd_cnt_q == CW'(TOTAL - 1)) issue_done_d = 1'b1;
        end
        if (pop) out_cnt_d = out_cnt_q + CW'(1);
        if (pop && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_d     = fifo_q;
    fifo_wp_d  = fifo_wp_q;
    fifo_rp_d  = fifo_rp_q;
    ram_vld_d  = ram_re;
    if (ram_vld_q) begin
      fifo_d[fifo_wp_q] = ram_rdata;
      fifo_wp_d         = ~fifo_wp_q;
    end
    if (pop) fifo_rp_d = ~fifo_rp_q;
    fifo_cnt_d = fifo_cnt_q + {1'b0, ram_vld_q} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_cnt_q    <= '0;
      wr_base_q    <= '0;
      frames_q     <= '0;
      err_short_q  <= 1'b0;
      err_nodone_q <= 1'b0;
      overrun_q    <= 1'b0;
      state_q      <= IDLE;
      rd_base_q    <= '0;
      rd_addr_q    <= '0;
      rd_cnt_q     <= '0;
      issue_done_q <= 1'b0;
      out_cnt_q    <= '0;
      ram_vld_q    <= 1'b0;
      fifo_wp_q    <= 1'b0;
      fifo_rp_q    <= 1'b0;
      fifo_cnt_q   <= '0;
    end else begin
      bin_cnt_q    <= bin_cnt_d;
      wr_base_q    <= wr_base_d;
      frames_q     <= frames_d;
      err_short_q  <= err_short_d;
      err_nodone_q <= err_nodone_d;
      overrun_q    <= overrun_d;
      state_q      <= state_d;
      rd_base_q    <= rd_base_d;
      rd_addr_q    <= rd_addr_d;
      rd_cnt_q     <= rd_cnt_d;
      issue_done_q <= issue_done_d;
      out_cnt_q    <= out_cnt_d;
      ram_vld_q    <= ram_vld_d;
      fifo_wp_q    <= fifo_wp_d;
      fifo_rp_q    <= fifo_rp_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  // Skid data needs no reset; occupancy gates its visibility.
  always_ff @(posedge clk) fifo_q <= fifo_d;

  assign err_short  = err_short_q;
  assign err_nodone = err_nodone_q;
  assign overrun    = overrun_q;

  mel_buf_ram #(.DEPTH(DEPTH), .OW(OW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (mel_in),
    .re    (ram_re),
    .raddr (rd_addr_q),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_mel_window_buffer.sv
// Directed + randomized bench for mel_window_buffer against a frame-level reference model.
module tb_mel_window_buffer;
  localparam int MB = 4;
  localparam int NF = 3;
  localparam int WW = MB * NF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mel_in = '0;
  logic        mel_valid = 1'b0;
  logic        mel_frame_done = 1'b0;
  logic        win_ready;
  logic        win_start = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        err_short, err_nodone, overrun;

  mel_window_buffer #(.MEL_BINS(MB), .OW(16), .NUM_FRAMES(NF)) dut (
    .clk(clk), .rst_n(rst_n), .mel_in(mel_in), .mel_valid(mel_valid),
    .mel_frame_done(mel_frame_done), .win_ready(win_ready), .win_start(win_start),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .err_short(err_short), .err_nodone(err_nodone), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] hist[$];
  logic [15:0] partial[$];
  logic [15:0] exp_win[$];
  int  bin = 0, stored = 0;
  bit  streaming = 0, spare_used = 0, gaps = 0;
  int  exp_short = 0, exp_nodone = 0, exp_overrun = 0;
  int  n_short = 0, n_nodone = 0, n_overrun = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      n_short   <= n_short + int'(err_short);
      n_nodone  <= n_nodone + int'(err_nodone);
      n_overrun <= n_overrun + int'(overrun);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] d, input bit done);
    if (gaps) repeat ($urandom_range(2)) cyc();
    mel_in = d; mel_valid = 1'b1; mel_frame_done = done;
    cyc();
    mel_valid = 1'b0; mel_frame_done = 1'b0;
    if (streaming && spare_used) exp_overrun++;
    else if (bin == MB - 1) begin
      foreach (partial[i]) hist.push_back(partial[i]);
      hist.push_back(d);
      partial.delete();
      bin = 0;
      if (!done) exp_nodone++;
      if (streaming) spare_used = 1;
      if (stored < NF) stored++;
    end else if (done) begin
      exp_short++; bin = 0; partial.delete();
    end else begin
      partial.push_back(d); bin++;
    end
  endtask

  task automatic send_frame(input int base, input bit rnd, input bit done);
    for (int b = 0; b < MB; b++)
      send_word(rnd ? 16'($urandom) : 16'(base + b), done && (b == MB - 1));
  endtask

  task automatic chk_ready(input string tag);
    chk(tag, {31'd0, win_ready}, {31'd0, (stored == NF) && !streaming});
  endtask

  task automatic chk_pulses();
    cyc();
    chk("err_short_cnt", n_short, exp_short);
    chk("err_nodone_cnt", n_nodone, exp_nodone);
    chk("overrun_cnt", n_overrun, exp_overrun);
  endtask

  task automatic start_window();
    chk_ready("win_ready_pre");
    win_start = 1'b1;
    cyc();
    win_start = 1'b0;
    exp_win.delete();
    for (int i = hist.size() - WW; i < hist.size(); i++) exp_win.push_back(hist[i]);
    streaming = 1; spare_used = 0;
    chk("win_ready_lock", {31'd0, win_ready}, 32'd0);
  endtask

  task automatic read_window(input int nwords, input int pct);
    int got = 0, n = 0;
    bit pstall = 0;
    logic [15:0] pd = '0;
    logic pl = 1'b0;
    while (got < nwords && n < 400) begin
      out_ready = ($urandom_range(99) < pct);
      if (pstall) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", {16'd0, out_data}, {16'd0, pd});
        chk("stall_last", {31'd0, out_last}, {31'd0, pl});
      end
      if (out_valid && out_ready) begin
        chk("win_data", {16'd0, out_data}, {16'd0, exp_win[got]});
        chk("win_last", {31'd0, out_last}, {31'd0, got == WW - 1});
        got++;
      end
      pstall = out_valid && !out_ready; pd = out_data; pl = out_last;
      cyc();
      n++;
    end
    out_ready = 1'b0;
    chk("win_count", got, nwords);
    if (nwords == WW) begin
      streaming = 0;
      chk("valid_drop", {31'd0, out_valid}, 32'd0);
      chk_ready("win_ready_post");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    repeat (3) cyc();
    chk("rst_outputs", {24'd0, win_ready, out_valid, out_last, err_short, err_nodone, overrun, 2'b0},
        32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Fill: frames f*16+b, window only once 3 frames are in.
    send_frame(16'h00, 0, 1); chk_ready("ready_f0");
    win_start = 1'b1; cyc(); win_start = 1'b0;
    repeat (3) cyc();
    chk("ignored_start", {31'd0, out_valid}, 32'd0);
    send_frame(16'h10, 0, 1); chk_ready("ready_f1");
    send_frame(16'h20, 0, 1); chk_ready("ready_f2");
    start_window();
    read_window(WW, 100);

    // Wrap: window spans slots 12,0,4 of a 16-word buffer.
    gaps = 1;
    send_frame(16'h30, 0, 1);
    send_frame(16'h40, 0, 1);
    send_frame(16'h50, 0, 1);
    start_window();
    read_window(WW, 50);

    // Short frame then a good frame; missing done.
    send_word(16'h0a0, 0); send_word(16'h0a1, 1);
    chk_pulses();
    chk_ready("ready_short");
    send_frame(16'h60, 0, 1);
    send_frame(16'h70, 0, 0);
    chk_pulses();
    start_window();
    read_window(WW, 70);

    // Overrun: spare slot fills, the next frame is dropped.
    start_window();
    send_frame(16'h80, 0, 1);
    send_frame(16'h90, 0, 1);
    chk_pulses();
    read_window(WW, 100);
    send_frame(16'ha0, 0, 1);
    chk_pulses();
    start_window();
    read_window(WW, 100);

    // Random frames, framing errors and backpressure.
    for (int r = 0; r < 3; r++) begin
      for (int f = 0; f < 4; f++) begin
        if ($urandom_range(4) == 0) begin
          int nb = $urandom_range(1, MB - 1);
          for (int b = 0; b < nb; b++) send_word(16'($urandom), b == nb - 1);
        end
        send_frame(0, 1, $urandom_range(4) != 0);
        chk_ready("ready_rand");
      end
      chk_pulses();
      start_window();
      read_window(WW, 60);
    end

    // Reset mid-stream.
    start_window();
    read_window(5, 100);
    rst_n = 1'b0;
    cyc();
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, win_ready}, 32'd0);
    rst_n = 1'b1;
    hist.delete(); partial.delete();
    bin = 0; stored = 0; streaming = 0; spare_used = 0;
    cyc();
    send_frame(0, 1, 1); chk_ready("ready_rst0");
    send_frame(0, 1, 1); chk_ready("ready_rst1");
    send_frame(0, 1, 1); chk_ready("ready_rst2");
    start_window();
    read_window(WW, 80);
    chk_pulses();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
